// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch slice.
// Optional lap feature is selected with STOPWATCH_LAP_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } sw_state_t;

   localparam int unsigned SW_COUNT_W = 14;
   localparam logic [SW_COUNT_W-1:0] SW_MAX_COUNT = 14'd9999;

endpackage

// File: rtl/stopwatch_counter_button_debounce.sv
// Per-button 2-flop synchroniser, debounce filter and rising-edge press detector.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // A bounce back to the accepted level clears the counter, so any change restarts the wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_q <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Button-controlled stopwatch: run/pause/clear FSM, tick prescaler, 0..9999 wrapping count.
// Define STOPWATCH_LAP_EN to add the btn_lap input and lap-freeze display.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned TICK_HZ         = 100,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start_stop,
   input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        btn_lap,
`endif
   output logic [15:0] value,
   output logic        running,
   output logic        overflow
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   sw_state_t              state;
   logic [PRE_W-1:0]       pre;
   logic [SW_COUNT_W-1:0]  count;
   logic [SW_COUNT_W-1:0]  count_d;
   logic [SW_COUNT_W-1:0]  shown;
   logic                   tick;
   logic                   wrap;
   logic                   clear_now;
   logic                   start_p;
   logic                   clear_p;
   logic                   unused_start_level;
   logic                   unused_clear_level;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_start_stop),
      .level   (unused_start_level),
      .press   (start_p)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .level   (unused_clear_level),
      .press   (clear_p)
   );

   assign tick = (state == RUN) && (pre == PRE_LAST);

   // Clear only acts outside RUN; in RUN a simultaneous start wins and clear is dropped.
   always_comb begin
      clear_now = clear_p && (state != RUN);
      wrap      = 1'b0;
      count_d   = count;
      if (clear_now) begin
         count_d = '0;
      end else if (tick) begin
         if (count == SW_MAX_COUNT) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count + 1'b1;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic                  lap_p;
   logic                  unused_lap_level;
   logic                  frozen;
   logic                  frozen_d;
   logic [SW_COUNT_W-1:0] lap_reg;
   logic [SW_COUNT_W-1:0] lap_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_lap),
      .level   (unused_lap_level),
      .press   (lap_p)
   );

   always_comb begin
      frozen_d = frozen;
      lap_d    = lap_reg;
      if (clear_now) begin
         frozen_d = 1'b0;
         lap_d    = '0;
      end else if (lap_p && (state == RUN)) begin
         frozen_d = ~frozen;
         if (!frozen) begin
            lap_d = count;
         end
      end
      shown = frozen_d ? lap_d : count_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frozen  <= 1'b0;
         lap_reg <= '0;
      end else begin
         frozen  <= frozen_d;
         lap_reg <= lap_d;
      end
   end
`else
   always_comb begin
      shown = count_d;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         pre      <= '0;
         count    <= '0;
         value    <= '0;
         overflow <= 1'b0;
      end else begin
         count    <= count_d;
         value    <= {{(16 - SW_COUNT_W){1'b0}}, shown};
         overflow <= clear_now ? 1'b0 : (overflow | wrap);
         pre      <= '0;
         case (state)
            IDLE: begin
               if (start_p && !clear_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               pre <= tick ? '0 : pre + 1'b1;
               if (start_p) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                  pre     <= '0;
               end
            end
            PAUSE: begin
               if (clear_p) begin
                  state <= IDLE;
               end else if (start_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: slow instance (DIV=10) for timing/FSM, fast instance (DIV=2) for wrap.
// Lap checks are compiled in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_clear = 1'b0;
   logic        btn_lap = 1'b0;
   logic        f_start = 1'b0;
   logic        f_clear = 1'b0;
   logic        f_lap = 1'b0;
   logic [15:0] value;
   logic        running;
   logic        overflow;
   logic [15:0] f_value;
   logic        f_running;
   logic        f_overflow;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_start_stop (btn_start),
      .btn_clear      (btn_clear),
`ifdef STOPWATCH_LAP_EN
      .btn_lap        (btn_lap),
`endif
      .value          (value),
      .running        (running),
      .overflow       (overflow)
   );

   stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(50), .DEBOUNCE_CYCLES(4)) dut_fast (
      .clk            (clk),
      .rst            (rst),
      .btn_start_stop (f_start),
      .btn_clear      (f_clear),
`ifdef STOPWATCH_LAP_EN
      .btn_lap        (f_lap),
`endif
      .value          (f_value),
      .running        (f_running),
      .overflow       (f_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive buttons; state change happens on the 7th edge after the drive.
   task automatic push(input logic s, input logic c, input logic l, input logic fast);
      if (fast) begin
         f_start = s; f_clear = c; f_lap = l;
      end else begin
         btn_start = s; btn_clear = c; btn_lap = l;
      end
      cyc(7);
   endtask

   task automatic release_all();
      btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
      f_start = 1'b0; f_clear = 1'b0; f_lap = 1'b0;
      cyc(8);
   endtask

   initial begin
      int unsigned rises;
      logic        prev;

      cyc(2);
      check("rst_value", 32'(value), 0);
      check("rst_running", 32'(running), 0);
      check("rst_overflow", 32'(overflow), 0);
      rst = 1'b0;
      cyc(2);

      // Start press; R denotes the edge where state becomes RUN.
      btn_start = 1'b1;
      cyc(6);
      check("start_lat_early", 32'(running), 0);
      cyc(1);
      check("start_lat", 32'(running), 1);
      btn_start = 1'b0;
      cyc(9);
      check("first_tick_early", 32'(value), 0);
      cyc(1);
      check("first_tick", 32'(value), 1);
      cyc(40);
      check("value_5", 32'(value), 5);

      btn_clear = 1'b1;
      cyc(7);
      check("clear_in_run_running", 32'(running), 1);
      cyc(3);
      check("clear_in_run_count", 32'(value), 6);
      btn_clear = 1'b0;

      // Pause lands on edge R+375, between count 37 (R+370) and 38 (R+380).
      cyc(308);
      btn_start = 1'b1;
      cyc(7);
      check("pause_running", 32'(running), 0);
      check("pause_value", 32'(value), 37);
      btn_start = 1'b0;
      cyc(50);
      check("pause_hold", 32'(value), 37);
      check("pause_overflow", 32'(overflow), 0);
      btn_clear = 1'b1;
      cyc(7);
      check("clear_pause_value", 32'(value), 0);
      check("clear_pause_running", 32'(running), 0);
      btn_clear = 1'b0;
      cyc(8);

      // Bounce: 10 two-cycle segments, then held high.
      rises = 0;
      prev  = running;
      for (int i = 0; i < 10; i++) begin
         btn_start = (i % 2 == 0);
         for (int k = 0; k < 2; k++) begin
            cyc(1);
            if (running && !prev) rises++;
            prev = running;
         end
      end
      btn_start = 1'b1;
      for (int k = 0; k < 15; k++) begin
         cyc(1);
         if (running && !prev) rises++;
         prev = running;
      end
      check("bounce_rises", rises, 1);
      check("bounce_running", 32'(running), 1);
      btn_start = 1'b0;
      cyc(8);

      // Simultaneous start+clear from PAUSE, then from RUN.
      push(1'b1, 1'b0, 1'b0, 1'b0);
      check("to_pause", 32'(running), 0);
      release_all();
      push(1'b1, 1'b1, 1'b0, 1'b0);
      check("both_pause_value", 32'(value), 0);
      check("both_pause_running", 32'(running), 0);
      release_all();
      push(1'b1, 1'b0, 1'b0, 1'b0);
      check("restart_running", 32'(running), 1);
      release_all();
      cyc(25);
      push(1'b1, 1'b1, 1'b0, 1'b0);
      check("both_run_running", 32'(running), 0);
      check("both_run_value", 32'(value), 4);
      release_all();
      cyc(30);
      check("both_run_hold", 32'(value), 4);

      // Wrap on the fast instance: count k appears at edge Rf+2k.
      push(1'b1, 1'b0, 1'b0, 1'b1);
      check("fast_running", 32'(f_running), 1);
      release_all();
      cyc(19990);
      check("fast_9999", 32'(f_value), 9999);
      check("fast_no_ovf", 32'(f_overflow), 0);
      cyc(2);
      check("fast_wrap_value", 32'(f_value), 0);
      check("fast_wrap_ovf", 32'(f_overflow), 1);
      push(1'b0, 1'b1, 1'b0, 1'b1);
      check("fast_clr_run_ovf", 32'(f_overflow), 1);
      check("fast_clr_run_running", 32'(f_running), 1);
      release_all();
      push(1'b1, 1'b0, 1'b0, 1'b1);
      check("fast_pause_ovf", 32'(f_overflow), 1);
      check("fast_pause_running", 32'(f_running), 0);
      release_all();
      push(1'b0, 1'b1, 1'b0, 1'b1);
      check("fast_clear_ovf", 32'(f_overflow), 0);
      check("fast_clear_value", 32'(f_value), 0);
      release_all();

      // Asynchronous reset mid-count.
      push(1'b1, 1'b0, 1'b0, 1'b0);
      release_all();
      cyc(30);
      #3 rst = 1'b1;
      #1;
      check("async_rst_value", 32'(value), 0);
      check("async_rst_running", 32'(running), 0);
      cyc(2);
      rst = 1'b0;
      cyc(30);
      check("post_rst_value", 32'(value), 0);
      check("post_rst_running", 32'(running), 0);

`ifdef STOPWATCH_LAP_EN
      // R3 = RUN edge; lap latched at R3+125 (count 12), released at R3+305 (count 30).
      push(1'b1, 1'b0, 1'b0, 1'b0);
      release_all();
      cyc(110);
      push(1'b0, 1'b0, 1'b1, 1'b0);
      check("lap_latch", 32'(value), 12);
      release_all();
      cyc(157);
      check("lap_hold", 32'(value), 12);
      cyc(8);
      push(1'b0, 1'b0, 1'b1, 1'b0);
      check("lap_release", 32'(value), 30);
      release_all();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
